// File: rtl/nandc_ecc_seq.sv
// Sector sequencer between host DMA stream, NAND data path and a 24-bit Hamming ECC engine.
// Optional saturating error counters on err_cnt_o when NANDC_ECC_ERRCNT_EN is defined.
module nandc_ecc_seq #(
  parameter int unsigned SECTORS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [31:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] eng_data_o,
  output logic        eng_valid_o,
  output logic        eng_sof_o,
  output logic        eng_eof_o,
  input  logic        eng_eof_i,
  input  logic [23:0] eng_ecc_i,
`ifdef NANDC_ECC_ERRCNT_EN
  output logic [15:0] err_cnt_o,
`endif
  output logic        stat_valid_o,
  output logic [1:0]  stat_o,
  output logic [11:0] err_loc_o,
  output logic [3:0]  stat_sect_o
);

  localparam logic [3:0] SectLast = 4'(SECTORS - 1);

  typedef enum logic [2:0] {
    StIdle, StData, StWaitEcc, StEccOut, StEccIn, StCheck, StNext, StDone
  } state_e;

  state_e      state_q;
  logic        mode_q;
  logic [6:0]  wcnt_q;
  logic [3:0]  sect_q;
  logic [23:0] comp_q;
  logic        comp_vld_q;
  logic [23:0] stored_q;
  logic        busy_q;
  logic        done_q;
  logic        stat_valid_q;
  logic [1:0]  stat_q;
  logic [11:0] err_loc_q;
  logic [3:0]  stat_sect_q;

  logic        in_data;
  logic        xfer;
  logic [23:0] syn;
  logic [11:0] syn_ev;
  logic [11:0] syn_od;
  logic [1:0]  syn_stat;

  assign in_data = (state_q == StData);
  assign xfer    = in_data & s_valid_i & m_ready_i;

  always_comb begin
    m_data_o  = '0;
    m_valid_o = 1'b0;
    s_ready_o = 1'b0;
    unique case (state_q)
      StData: begin
        m_data_o  = s_data_i;
        m_valid_o = s_valid_i;
        s_ready_o = m_ready_i;
      end
      StEccOut: begin
        m_data_o  = {8'hFF, comp_q};
        m_valid_o = 1'b1;
      end
      StEccIn: s_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign eng_valid_o = xfer;
  assign eng_data_o  = in_data ? s_data_i : '0;
  assign eng_sof_o   = xfer & (wcnt_q == 7'd0);
  assign eng_eof_o   = xfer & (wcnt_q == 7'd127);

  // A single flipped data bit leaves the even/odd halves exactly complementary,
  // with the odd half spelling out the bit address.
  always_comb begin
    syn    = comp_q ^ stored_q;
    syn_ev = syn[11:0];
    syn_od = syn[23:12];
    if (syn == 24'd0) begin
      syn_stat = 2'b00;
    end else if ((syn_ev ^ syn_od) == 12'hFFF) begin
      syn_stat = 2'b01;
    end else if ((syn & (syn - 24'd1)) == 24'd0) begin
      syn_stat = 2'b10;
    end else begin
      syn_stat = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      wcnt_q       <= '0;
      sect_q       <= '0;
      comp_q       <= '0;
      comp_vld_q   <= 1'b0;
      stored_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_q       <= '0;
      err_loc_q    <= '0;
      stat_sect_q  <= '0;
    end else begin
      done_q       <= 1'b0;
      stat_valid_q <= 1'b0;
      if (eng_eof_i) begin
        comp_q     <= eng_ecc_i;
        comp_vld_q <= 1'b1;
      end
      if (state_q == StIdle) begin
        if (start_i) begin
          state_q    <= StData;
          mode_q     <= mode_i;
          busy_q     <= 1'b1;
          wcnt_q     <= '0;
          sect_q     <= '0;
          comp_vld_q <= 1'b0;
        end
      end else if (abort_i) begin
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        wcnt_q     <= '0;
        sect_q     <= '0;
        comp_vld_q <= 1'b0;
      end else begin
        unique case (state_q)
          StData: begin
            if (xfer) begin
              wcnt_q <= wcnt_q + 7'd1;
              if (wcnt_q == 7'd127) state_q <= mode_q ? StEccIn : StWaitEcc;
            end
          end
          StWaitEcc: if (comp_vld_q) state_q <= StEccOut;
          StEccOut:  if (m_ready_i) state_q <= StNext;
          StEccIn: begin
            if (s_valid_i) begin
              stored_q <= s_data_i[23:0];
              state_q  <= StCheck;
            end
          end
          StCheck: begin
            if (comp_vld_q) begin
              stat_valid_q <= 1'b1;
              stat_q       <= syn_stat;
              err_loc_q    <= (syn_stat == 2'b01) ? syn_od : 12'd0;
              stat_sect_q  <= sect_q;
              state_q      <= StNext;
            end
          end
          StNext: begin
            if (sect_q == SectLast) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sect_q     <= sect_q + 4'd1;
              comp_vld_q <= 1'b0;
              state_q    <= StData;
            end
          end
          StDone: begin
            state_q <= StIdle;
            sect_q  <= '0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign stat_valid_o = stat_valid_q;
  assign stat_o       = stat_q;
  assign err_loc_o    = err_loc_q;
  assign stat_sect_o  = stat_sect_q;

`ifdef NANDC_ECC_ERRCNT_EN
  logic [7:0] corr_cnt_q;
  logic [7:0] unc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else if (stat_valid_q) begin
      if ((stat_q == 2'b01) && (corr_cnt_q != 8'hFF)) corr_cnt_q <= corr_cnt_q + 8'd1;
      if ((stat_q == 2'b11) && (unc_cnt_q != 8'hFF)) unc_cnt_q <= unc_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = {unc_cnt_q, corr_cnt_q};
`endif

endmodule
